// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the 1-to-32 symbol distributor.
package demux_pkg;

  localparam int NUM_OUT = 32;
  localparam int SEL_W   = 5;
  localparam int DATA_W  = 2;
  localparam int CNT_W   = 16;

  typedef logic [DATA_W-1:0] sym_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [SEL_W:0]    occ_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Number of set bits in a lane mask; result range 0..NUM_OUT fits occ_t.
  function automatic occ_t popcount(input logic [NUM_OUT-1:0] mask);
    occ_t acc;
    acc = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      acc = acc + occ_t'(mask[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/demux_if.sv
// Upstream beat and per-lane drain handshake bundle for demux_dist.
interface demux_if;
  import demux_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  sel_t                      in_sel;
  logic                      in_bcast;
  sym_t                      in_data;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;

  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output lane.
module demux_slot
  import demux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  sym_t din,
  input  logic rdy,
  output logic valid,
  output sym_t data,
  output logic free,
  output logic valid_nxt
);

  logic valid_d, valid_q;
  sym_t data_d, data_q;

  // A load wins over a same-edge pop, so pop+push keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid     = valid_q;
  assign data      = data_q;
  assign free      = !valid_q || rdy;
  assign valid_nxt = valid_d;

endmodule

// File: rtl/demux_dist.sv
// Registered 1-to-32 distributor: steers or broadcasts each upstream symbol
// into per-lane holding slots that drain independently.
module demux_dist
  import demux_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  demux_if.slave   bus,
  output occ_t     occupancy,
  output cnt_t     acc_cnt
);

  logic [NUM_OUT-1:0]        sel_oh;
  logic [NUM_OUT-1:0]        free_vec;
  logic [NUM_OUT-1:0]        load_vec;
  logic [NUM_OUT-1:0]        valid_nxt;
  logic [NUM_OUT-1:0]        slot_valid;
  logic [NUM_OUT*DATA_W-1:0] slot_data;
  logic                      in_ready_w;
  logic                      accept;

  occ_t occupancy_d, occupancy_q;
  cnt_t acc_cnt_d, acc_cnt_q;

  always_comb begin
    sel_oh              = '0;
    sel_oh[bus.in_sel]  = 1'b1;
  end

  // in_ready passes out_ready straight through so a draining slot refills
  // on the same edge without a bubble.
  always_comb begin
    in_ready_w = bus.in_bcast ? (&free_vec) : free_vec[bus.in_sel];
    accept     = bus.in_valid && in_ready_w;
    load_vec   = '0;
    if (accept) begin
      load_vec = bus.in_bcast ? {NUM_OUT{1'b1}} : sel_oh;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vec[k]),
      .din       (bus.in_data),
      .rdy       (bus.out_ready[k]),
      .valid     (slot_valid[k]),
      .data      (slot_data[k*DATA_W +: DATA_W]),
      .free      (free_vec[k]),
      .valid_nxt (valid_nxt[k])
    );
  end

  always_comb begin
    occupancy_d = popcount(valid_nxt);
    acc_cnt_d   = acc_cnt_q + cnt_t'(accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      occupancy_q <= occupancy_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = slot_valid;
  assign bus.out_data  = slot_data;
  assign occupancy     = occupancy_q;
  assign acc_cnt       = acc_cnt_q;

endmodule
